// File: rtl/mac_arbiter_if.sv
// Requester, response and MAC-side signals of mac_arbiter.
// slave: arbiter view; master: requesters + MAC datapath view.
interface mac_arbiter_if #(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int ACCW = 16
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0][W-1:0] req_a;
    logic [NREQ-1:0][W-1:0] req_b;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        rsp_valid;
    logic [NREQ-1:0]        rsp_ready;
    logic [ACCW-1:0]        rsp_data;
    logic                   rsp_err;
    logic                   mac_clear;
    logic [W-1:0]           mac_a;
    logic [W-1:0]           mac_b;
    logic                   mac_valid_in;
    logic [ACCW-1:0]        mac_f;
    logic                   mac_valid_out;
    logic                   busy;
    logic [GW-1:0]          grant_id;

    modport slave (
        input  req_valid, req_a, req_b, req_last, rsp_ready,
        input  mac_f, mac_valid_out,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mac_clear, mac_a, mac_b, mac_valid_in,
        output busy, grant_id
    );

    modport master (
        output req_valid, req_a, req_b, req_last, rsp_ready,
        output mac_f, mac_valid_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mac_clear, mac_a, mac_b, mac_valid_in,
        input  busy, grant_id
    );
endinterface

// File: rtl/mac_arbiter.sv
// Job-granular arbiter sharing one pipelined MAC among NREQ requesters.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module mac_arbiter #(
    parameter int NREQ   = 2,
    parameter int W      = 8,
    parameter int ACCW   = 16,
    parameter int MAXLEN = 16
) (
    input logic          clk,
    input logic          reset,
    mac_arbiter_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        RESP
    } state_t;

    state_t          state, state_nx;
    logic [GW-1:0]   owner, owner_nx;
    logic [CW-1:0]   issued, issued_nx;
    logic [CW-1:0]   returned, returned_nx;
    logic            err, err_nx;
    logic [ACCW-1:0] result, result_nx;
    logic [GW-1:0]   pick;
    logic            any_req;
    logic            beat;
`ifndef ARB_FIXED_PRIO_EN
    logic [GW-1:0]   last_grant, last_grant_nx;
`endif

    // Choose the next owner from the currently valid requesters
    always_comb begin
        pick    = '0;
        any_req = |bus.req_valid;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) pick = GW'(i);
        end
`else
        // scan from farthest to nearest so the nearest after last_grant wins
        for (int i = NREQ; i >= 1; i--) begin
            if (bus.req_valid[(int'(last_grant) + i) % NREQ])
                pick = GW'((int'(last_grant) + i) % NREQ);
        end
`endif
    end

    // Outputs depend on registered state; only the MAC operand path sees req_valid
    always_comb begin
        beat             = (state == STREAM) && bus.req_valid[owner];
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        if (state == STREAM) bus.req_ready[owner] = 1'b1;
        if (state == RESP)   bus.rsp_valid[owner] = 1'b1;
        bus.mac_clear    = (state == CLEAR);
        bus.mac_valid_in = beat;
        bus.mac_a        = beat ? bus.req_a[owner] : '0;
        bus.mac_b        = beat ? bus.req_b[owner] : '0;
        bus.rsp_data     = result;
        bus.rsp_err      = (state == RESP) && err;
        bus.busy         = (state != IDLE);
        bus.grant_id     = owner;
    end

    // Job sequencing: grant, clear, stream, count results back, respond
    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        issued_nx   = issued;
        returned_nx = returned;
        err_nx      = err;
        result_nx   = result;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_nx = last_grant;
`endif
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    owner_nx = pick;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                issued_nx   = '0;
                returned_nx = '0;
                err_nx      = 1'b0;
                state_nx    = STREAM;
            end
            STREAM: begin
                if (bus.mac_valid_out) returned_nx = returned + CW'(1);
                if (beat) begin
                    issued_nx = issued + CW'(1);
                    if (bus.req_last[owner]) begin
                        state_nx = DRAIN;
                    end else if (issued_nx == CW'(MAXLEN)) begin
                        err_nx   = 1'b1;
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.mac_valid_out) begin
                    returned_nx = returned + CW'(1);
                    if (returned_nx == issued) begin
                        result_nx = bus.mac_f;
                        state_nx  = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready[owner]) begin
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_nx = owner;
`endif
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and job registers; reset aborts any job in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= '0;
            issued   <= '0;
            returned <= '0;
            err      <= 1'b0;
            result   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= GW'(NREQ - 1);
`endif
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            issued   <= issued_nx;
            returned <= returned_nx;
            err      <= err_nx;
            result   <= result_nx;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= last_grant_nx;
`endif
        end
    end
endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: job table, per-requester scoreboard,
// two-stage MAC model, grant order and async reset sequences.
`timescale 1ns/1ps
module tb_mac_arbiter;
    localparam int NREQ   = 2;
    localparam int W      = 8;
    localparam int ACCW   = 16;
    localparam int MAXLEN = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mac_arbiter_if #(.NREQ(NREQ), .W(W), .ACCW(ACCW)) bus ();

    mac_arbiter #(
        .NREQ(NREQ), .W(W), .ACCW(ACCW), .MAXLEN(MAXLEN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // MAC datapath model: product stage, then accumulate stage
    logic signed [2*W-1:0]  p1 = '0;
    logic                   v1 = 1'b0;
    logic signed [ACCW-1:0] f_q = '0;
    logic                   vo_q = 1'b0;
    always @(posedge clk) begin
        if (bus.mac_clear) begin
            v1   <= 1'b0;
            vo_q <= 1'b0;
            f_q  <= '0;
        end else begin
            p1   <= $signed(bus.mac_a) * $signed(bus.mac_b);
            v1   <= bus.mac_valid_in;
            vo_q <= v1;
            if (v1) f_q <= f_q + ACCW'(p1);
        end
    end
    assign bus.mac_f         = f_q;
    assign bus.mac_valid_out = vo_q;

    typedef struct {
        int              r;
        int              len;
        bit              gap;
        bit              hold;
        logic [5:0][W-1:0] a;
        logic [5:0][W-1:0] b;
        logic [ACCW-1:0] exp;
        bit              exp_err;
        int              exp_beats;
    } job_t;

    typedef struct {
        logic [ACCW-1:0] d;
        bit              e;
        int              nb;
        bit              hold;
    } sb_t;

    job_t            jt[$];
    int              jq[NREQ][$];
    sb_t             sbq[NREQ][$];
    int              egq[$];
    int              k[NREQ];
    bit              active[NREQ];
    int              hcnt[NREQ];
    logic [ACCW-1:0] hdata[NREQ];
    int              cyc = 0;
    int              clr_cnt = 0;
    int              vin_cnt = 0;
    int              n_chk = 0;
    int              n_fail = 0;
    int              av[6];
    int              bv[6];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail(string name, int act, int req);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic void add(int r, int len, int a_v[6], int b_v[6],
                                int exp, bit err, int nb, bit gap, bit hold);
        job_t j;
        j.r    = r;
        j.len  = len;
        j.gap  = gap;
        j.hold = hold;
        for (int i = 0; i < 6; i++) begin
            j.a[i] = W'(a_v[i]);
            j.b[i] = W'(b_v[i]);
        end
        j.exp       = ACCW'(exp);
        j.exp_err   = err;
        j.exp_beats = nb;
        jt.push_back(j);
        jq[r].push_back(jt.size() - 1);
    endfunction

    function automatic bit tb_busy();
        bit b = 1'b0;
        for (int r = 0; r < NREQ; r++)
            if (active[r] || jq[r].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic tb_clear();
        for (int r = 0; r < NREQ; r++) begin
            jq[r].delete();
            sbq[r].delete();
            active[r] = 1'b0;
            k[r]      = 0;
            hcnt[r]   = 0;
        end
        egq.delete();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
    endtask

    task automatic step();
        logic [NREQ-1:0] own;
        logic            vin_exp;
        job_t            j;
        sb_t             e;
        @(negedge clk);
        cyc++;
        bus.rsp_ready = '0;
        own = '0;
        own[bus.grant_id] = 1'b1;
        chk("req_ready_owner", 32'(bus.req_ready & ~own), 0);
        chk("rsp_valid_owner", 32'(bus.rsp_valid & ~own), 0);
        if (bus.mac_clear) begin
            clr_cnt++;
            if (egq.size() == 0) fail("grant_unexpected", 32'(bus.grant_id), -1);
            else chk("grant_id", 32'(bus.grant_id), egq.pop_front());
        end
        for (int r = 0; r < NREQ; r++) begin
            if (active[r] && hcnt[r] > 0 && !bus.rsp_valid[r])
                fail("rsp_hold_valid", 0, 1);
            if (bus.rsp_valid[r]) begin
                if (!active[r] || sbq[r].size() == 0) begin
                    fail("rsp_unexpected", r, -1);
                end else begin
                    e = sbq[r][0];
                    if (e.hold && hcnt[r] < 5) begin
                        if (hcnt[r] == 0) hdata[r] = bus.rsp_data;
                        else chk("rsp_hold_data", 32'(bus.rsp_data), 32'(hdata[r]));
                        hcnt[r]++;
                    end else begin
                        void'(sbq[r].pop_front());
                        chk("rsp_data", 32'(bus.rsp_data), 32'(e.d));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.e));
                        chk("beats_accepted", k[r], e.nb);
                        bus.rsp_ready[r] = 1'b1;
                        active[r] = 1'b0;
                        hcnt[r]   = 0;
                        void'(jq[r].pop_front());
                    end
                end
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (!active[r] && jq[r].size() > 0) begin
                j = jt[jq[r][0]];
                active[r] = 1'b1;
                k[r]      = 0;
                sbq[r].push_back('{d: j.exp, e: j.exp_err,
                                   nb: j.exp_beats, hold: j.hold});
            end
            bus.req_valid[r] = 1'b0;
            bus.req_last[r]  = 1'b0;
            if (active[r]) begin
                j = jt[jq[r][0]];
                if (k[r] < j.len && !(j.gap && (cyc % 2 == 1))) begin
                    bus.req_valid[r] = 1'b1;
                    bus.req_a[r]     = j.a[k[r]];
                    bus.req_b[r]     = j.b[k[r]];
                    bus.req_last[r]  = (k[r] == j.len - 1);
                end
            end
        end
        #1;
        vin_exp = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (bus.req_valid[r] && bus.req_ready[r]) begin
                j = jt[jq[r][0]];
                vin_exp = 1'b1;
                chk("mac_a", 32'(bus.mac_a), 32'(j.a[k[r]]));
                chk("mac_b", 32'(bus.mac_b), 32'(j.b[k[r]]));
                k[r]++;
            end
        end
        chk("mac_valid_in", 32'(bus.mac_valid_in), 32'(vin_exp));
        if (bus.mac_valid_in) vin_cnt++;
    endtask

    task automatic run(int budget, int stop_k);
        int n = 0;
        while (tb_busy() && n < budget) begin
            if (stop_k > 0 && k[0] >= stop_k) return;
            step();
            n++;
        end
        if (n >= budget) begin
            fail("timeout", n, budget);
            tb_clear();
        end
    endtask

    task automatic finish_phase(string tag);
        @(negedge clk);
        bus.rsp_ready = '0;
        chk({tag, "_idle"}, 32'(bus.busy), 0);
        chk({tag, "_grants_left"}, egq.size(), 0);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_mac_clear"}, 32'(bus.mac_clear), 0);
        chk({tag, "_mac_valid_in"}, 32'(bus.mac_valid_in), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        chk({tag, "_mac_a"}, 32'(bus.mac_a), 0);
        chk({tag, "_mac_b"}, 32'(bus.mac_b), 0);
        chk({tag, "_grant_id"}, 32'(bus.grant_id), 0);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset(tag);
        tb_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int c0;
        int v0;
        tb_clear();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        reset = 1'b1;

        // single 3-beat job on r0
        av = '{1, 2, 3, 0, 0, 0};   bv = '{4, 5, 6, 0, 0, 0};
        add(0, 3, av, bv, 32, 0, 3, 0, 0);
        egq.push_back(0);
        c0 = clr_cnt;
        v0 = vin_cnt;
        run(200, 0);
        finish_phase("single");
        chk("single_clear_pulses", clr_cnt - c0, 1);
        chk("single_vin_pulses", vin_cnt - v0, 3);

        // both valid out of reset: r0 then r1
        do_reset("rst2");
        av = '{2, 1, 0, 0, 0, 0};   bv = '{3, 1, 0, 0, 0, 0};
        add(0, 2, av, bv, 7, 0, 2, 0, 0);
        av = '{-2, 5, 0, 0, 0, 0};  bv = '{4, 1, 0, 0, 0, 0};
        add(1, 2, av, bv, -3, 0, 2, 0, 0);
        egq.push_back(0);
        egq.push_back(1);
        run(200, 0);
        finish_phase("pair");

        // four back-to-back jobs per requester
        for (int j = 0; j < 4; j++) begin
            av = '{j + 1, 1, 0, 0, 0, 0};   bv = '{2, -1, 0, 0, 0, 0};
            add(0, 2, av, bv, 2 * (j + 1) - 1, 0, 2, 0, 0);
            av = '{-(j + 1), 2, 0, 0, 0, 0}; bv = '{3, 2, 0, 0, 0, 0};
            add(1, 2, av, bv, -3 * (j + 1) + 4, 0, 2, 0, 0);
        end
`ifdef ARB_FIXED_PRIO_EN
        egq = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        egq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        run(400, 0);
        finish_phase("contend");

        // truncation at MAXLEN, then exactly MAXLEN with last
        av = '{1, 1, 1, 1, 1, 1};   bv = '{1, 1, 1, 1, 1, 1};
        add(0, 6, av, bv, 4, 1, 4, 0, 0);
        egq.push_back(0);
        run(200, 0);
        finish_phase("trunc");
        av = '{1, 2, 3, 4, 0, 0};   bv = '{1, 1, 1, 1, 0, 0};
        add(1, 4, av, bv, 10, 0, 4, 0, 0);
        egq.push_back(1);
        run(200, 0);
        finish_phase("maxlen");

        // extreme operands with held response, then gapped stream
        av = '{-128, 0, 0, 0, 0, 0}; bv = '{-128, 0, 0, 0, 0, 0};
        add(0, 1, av, bv, 16384, 0, 1, 0, 1);
        egq.push_back(0);
        run(200, 0);
        finish_phase("hold");
        av = '{3, -4, 5, 0, 0, 0};  bv = '{2, 2, 2, 0, 0, 0};
        add(1, 3, av, bv, 8, 0, 3, 1, 0);
        egq.push_back(1);
        run(200, 0);
        finish_phase("gap");

        // async reset in the middle of a stream
        av = '{7, 7, 7, 0, 0, 0};   bv = '{7, 7, 7, 0, 0, 0};
        add(0, 3, av, bv, 147, 0, 3, 0, 0);
        egq.push_back(0);
        run(200, 2);
        chk("midrst_two_beats", k[0], 2);
        @(posedge clk);
        #2;
        chk("midrst_busy_before", 32'(bus.busy), 1);
        reset = 1'b0;
        #1;
        chk_reset("async");
        tb_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        av = '{1, 0, 0, 0, 0, 0};   bv = '{9, 0, 0, 0, 0, 0};
        add(0, 1, av, bv, 9, 0, 1, 0, 0);
        egq.push_back(0);
        run(200, 0);
        finish_phase("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Shares one pipelined MAC unit among `NREQ` requesters at dot-product-job granularity. Each requester streams operand pairs terminated by a `last` flag, and the arbiter performs these steps for each job:

- grants the MAC to one requester;
- clears the MAC;
- forwards the operand beats;
- counts the MAC results back;
- returns the final accumulated value over a per-requester response handshake.

It sits between the matrix-vector front ends and a single `part2_mac`-style datapath (clear / a / b / valid_in → f / valid_out).

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `W`, 8: signed operand width.
- `ACCW`, 16: signed result width.
- `MAXLEN`, 16: maximum beats per job.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: operand beat valid, per requester.
- `req_ready` out NREQ: operand beat accepted, per requester.
- `req_a`, `req_b` in NREQ×W: signed operands, per requester.
- `req_last` in NREQ: final beat of job.
- `rsp_valid` out NREQ: result valid, per requester.
- `rsp_ready` in NREQ: result consumed.
- `rsp_data` out ACCW: result, shared bus, meaningful only where `rsp_valid` is set.
- `rsp_err` out 1: qualifies `rsp_data`; job was truncated at MAXLEN.
- `mac_clear` out 1: MAC accumulator clear.
- `mac_a`, `mac_b` out W: MAC operands.
- `mac_valid_in` out 1: MAC operand valid.
- `mac_f` in ACCW: MAC running accumulation.
- `mac_valid_out` in 1: MAC result valid, one per accepted operand, fixed latency ≥1.
- `busy` out 1: state ≠ IDLE.
- `grant_id` out $clog2(NREQ): current owner; holds last owner in IDLE.

## Operation
- FSM states: IDLE → CLEAR → STREAM → DRAIN → RESP → IDLE.
- IDLE:
  - If any `req_valid` is set, select the owner by round-robin starting at `last_grant+1` (wrapping at NREQ).
  - Register the owner in `grant_id` and go to CLEAR.
  - No `req_ready` is asserted in IDLE.
- CLEAR:
  - `mac_clear`=1 for exactly one cycle.
  - Zero both counters `issued` and `returned` and the sticky `err`.
  - Go to STREAM.
- STREAM:
  - `req_ready[owner]`=1 and all other `req_ready`=0.
  - A beat is `req_valid[owner] && req_ready[owner]`.
  - On a beat: `mac_valid_in`=1 in the same cycle, `mac_a`/`mac_b` = the owner's operands combinationally, and `issued`++.
  - Go to DRAIN on a beat with `req_last`.
  - Also go to DRAIN on the beat that makes `issued`==MAXLEN without `last`; that case sets `err`.
  - In the truncation case the remaining requester beats stay unaccepted until the requester's next grant. The requester is responsible for flushing them.
- DRAIN:
  - `req_ready`=0.
  - `returned` increments on every `mac_valid_out`, in STREAM as well as DRAIN.
  - When `mac_valid_out` arrives and `returned+1`==`issued`, capture `mac_f` into the result register and go to RESP.
- RESP:
  - `rsp_valid[owner]`=1, `rsp_data`=result, `rsp_err`=`err`.
  - On `rsp_ready[owner]`: set `last_grant`←owner and go to IDLE.
- Arithmetic: the arbiter performs none; the result is `mac_f` verbatim. The counters are $clog2(MAXLEN+1) bits and never wrap, because `issued` ≤ MAXLEN.
- A `mac_valid_out` seen in IDLE, CLEAR or RESP is ignored; a compliant MAC never produces one.

## Timing
- Reset values:
  - state=IDLE.
  - `last_grant`=NREQ-1, so requester 0 wins first.
  - `grant_id`=0.
  - `req_ready`, `rsp_valid`, `mac_clear`, `mac_valid_in`, `busy`, `rsp_err`=0.
  - `rsp_data`, `mac_a`, `mac_b`=0.
- Reset deasserted mid-job aborts the job. Partial MAC state is discarded because the next job always passes through CLEAR.
- Latency:
  - Request visible in IDLE to first possible beat accept: 2 cycles (IDLE, CLEAR).
  - Final beat to `rsp_valid`: MAC latency + 1 cycles.
- `req_ready` and `rsp_valid` are functions of registered state only and carry no combinational path from `req_valid` or `rsp_ready`.
- The owner's `req_valid` may drop between beats; the arbiter waits in STREAM indefinitely.
- A final `mac_valid_out` coinciding with the last-beat cycle cannot occur; the `returned` comparison is only evaluated in DRAIN. Counting in STREAM covers the overlap of earlier results.
- A new arbitration cannot start in the same cycle as the RESP handshake; IDLE always lasts ≥1 cycle.

## Configuration
- `ARB_FIXED_PRIO_EN`:
  - Defined: IDLE selects the lowest-index requester with `req_valid`, and `last_grant` is unused.
  - Undefined (default): round-robin as described above.

## Test plan
- Single job, requester 0: a=(1,2,3), b=(4,5,6), last on 3rd beat → `mac_clear` pulses once, 3 `mac_valid_in` pulses, `rsp_valid[0]` with `rsp_data`=32, `rsp_err`=0.
- Both requesters valid from reset, each with a 2-beat job (r0: 2·3+1·1=7; r1: (-2)·4+5·1=-3) → r0 served first, then r1; responses 7 and −3; `req_ready[1]` stays 0 throughout r0's job.
- Back-to-back contention across 4 jobs per requester → grants alternate 0,1,0,1,0,1,0,1 (default). With `ARB_FIXED_PRIO_EN` defined, grants are all r0 first while r0 keeps `req_valid` set.
- Truncation: MAXLEN=4, a=b=1 for 6 beats with last on the 6th → exactly 4 beats accepted, `rsp_data`=4, `rsp_err`=1.
- Single-beat job, a=−128, b=−128, last=1 → `rsp_data`=16384. Also: the owner's `req_valid` gaps between beats do not affect the result, and holding `rsp_ready`=0 for 5 cycles keeps `rsp_valid` and `rsp_data` stable.
- Reset asserted during STREAM after 2 beats → outputs return to reset values asynchronously. A subsequent job a=(1), b=(9) returns 9, proving the accumulator was cleared.
